// File: rtl/trace_capture_ctrl_if.sv
// ============================================================================
// trace_capture_ctrl_if
// Sample/arm/abort/readout and BRAM port signals for trace_capture_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface trace_capture_ctrl_if #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
);
  logic             enable;
  logic [WIDTH-1:0] data;
  logic             trigger;
  logic             arm__ENA;
  logic [AW-1:0]    arm_postCount;
  logic             arm__RDY;
  logic             abort__ENA;
  logic             abort__RDY;
  logic             bramWrite__ENA;
  logic [AW-1:0]    bramWrite_addr;
  logic [WIDTH-1:0] bramWrite_data;
  logic             bramWrite__RDY;
  logic             readNext__ENA;
  logic             readNext__RDY;
  logic             readNext_last;
  logic             bramRead__ENA;
  logic [AW-1:0]    bramRead_addr;
  logic             bramRead__RDY;
  logic [1:0]       state;
  logic [AW-1:0]    trigAddr;
  logic             trigValid;
  logic [AW:0]      fill;
  logic             overflow;

  // Controller side.
  modport slave (
    input  enable, data, trigger, arm__ENA, arm_postCount, abort__ENA,
           bramWrite__RDY, readNext__ENA, bramRead__RDY,
    output arm__RDY, abort__RDY, bramWrite__ENA, bramWrite_addr, bramWrite_data,
           readNext__RDY, readNext_last, bramRead__ENA, bramRead_addr,
           state, trigAddr, trigValid, fill, overflow
  );

  // Sample source, BRAM and readout side.
  modport master (
    output enable, data, trigger, arm__ENA, arm_postCount, abort__ENA,
           bramWrite__RDY, readNext__ENA, bramRead__RDY,
    input  arm__RDY, abort__RDY, bramWrite__ENA, bramWrite_addr, bramWrite_data,
           readNext__RDY, readNext_last, bramRead__ENA, bramRead_addr,
           state, trigAddr, trigValid, fill, overflow
  );
endinterface

`default_nettype wire

// File: rtl/trace_capture_ctrl.sv
// ============================================================================
// trace_capture_ctrl
// Circular pre-trigger capture, post-trigger count, then oldest-first readout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_capture_ctrl #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  trace_capture_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] C_ONE_A   = 1;
  localparam logic [AW:0]   C_ONE_F   = 1;
  localparam logic [AW:0]   C_DEPTH_F = DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_trig_addr;
  logic [AW-1:0] r_post_count;
  logic [AW-1:0] r_remaining;
  logic [AW:0]   r_fill;
  logic [AW:0]   r_rd_left;
  logic          r_trig_valid;
  logic          r_overflow;

  logic          w_active;
  logic          w_wr;
  logic          w_arm;
  logic          w_abort;
  logic          w_trig_hit;
  logic          w_to_done;
  logic          w_rd_rdy;
  logic          w_rd;
  logic [AW-1:0] w_wptr_next;
  logic [AW:0]   w_fill_next;

  assign w_active    = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_wr        = w_active && bus.enable && bus.bramWrite__RDY;
  assign w_arm       = bus.arm__ENA && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_abort     = bus.abort__ENA && w_active;
  assign w_trig_hit  = (r_state == ST_ARMED) && w_wr && bus.trigger;
  assign w_wptr_next = w_wr ? (r_wptr + C_ONE_A) : r_wptr;
  assign w_fill_next = (w_wr && (r_fill != C_DEPTH_F)) ? (r_fill + C_ONE_F) : r_fill;

  // Abort takes priority over a same-cycle trigger; both lead to DONE.
  assign w_to_done = w_abort
                  || (w_trig_hit && (r_post_count == '0))
                  || ((r_state == ST_POST) && w_wr && (r_remaining == C_ONE_A));

  // A pending arm blocks reads so the capture is not consumed while restarting.
  assign w_rd_rdy = (r_state == ST_DONE) && (r_rd_left != '0) && bus.bramRead__RDY
                 && !bus.arm__ENA;
  assign w_rd     = bus.readNext__ENA && w_rd_rdy;

  assign bus.arm__RDY       = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.abort__RDY     = w_active;
  assign bus.bramWrite__ENA = w_wr;
  assign bus.bramWrite_addr = r_wptr;
  assign bus.bramWrite_data = bus.data;
  assign bus.readNext__RDY  = w_rd_rdy;
  assign bus.readNext_last  = (r_rd_left == C_ONE_F);
  assign bus.bramRead__ENA  = w_rd;
  assign bus.bramRead_addr  = r_rptr;
  assign bus.state          = r_state;
  assign bus.trigAddr       = r_trig_addr;
  assign bus.trigValid      = r_trig_valid;
  assign bus.fill           = r_fill;
  assign bus.overflow       = r_overflow;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_trig_addr  <= '0;
      r_post_count <= '0;
      r_remaining  <= '0;
      r_fill       <= '0;
      r_rd_left    <= '0;
      r_trig_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_wptr <= w_wptr_next;
      r_fill <= w_fill_next;
      if (w_active && bus.enable && !bus.bramWrite__RDY) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        ST_ARMED: begin
          if (w_trig_hit && !w_abort) begin
            r_trig_addr  <= r_wptr;
            r_trig_valid <= 1'b1;
            r_remaining  <= r_post_count;
            if (!w_to_done) begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (w_wr) begin
            r_remaining <= r_remaining - C_ONE_A;
          end
        end
        ST_DONE: begin
          if (w_rd) begin
            r_rptr    <= r_rptr + C_ONE_A;
            r_rd_left <= r_rd_left - C_ONE_F;
          end
        end
        default: ;
      endcase

      // Once the buffer has wrapped, the oldest entry sits at the write pointer.
      if (w_to_done) begin
        r_state   <= ST_DONE;
        r_rptr    <= (w_fill_next == C_DEPTH_F) ? w_wptr_next : '0;
        r_rd_left <= w_fill_next;
      end

      if (w_arm) begin
        r_state      <= ST_ARMED;
        r_wptr       <= '0;
        r_fill       <= '0;
        r_rd_left    <= '0;
        r_overflow   <= 1'b0;
        r_trig_valid <= 1'b0;
        r_trig_addr  <= '0;
        r_post_count <= bus.arm_postCount;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_trace_capture_ctrl.sv
// ============================================================================
// tb_trace_capture_ctrl
// Scoreboard bench: reference model queues expected BRAM writes/reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trace_capture_ctrl;
  localparam int DEPTH = 16;
  localparam int WIDTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  trace_capture_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) ifc ();
  trace_capture_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  typedef struct { int addr; logic [WIDTH-1:0] data; } wr_t;
  typedef struct { int addr; bit last; } rd_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_wq[$];
  rd_t exp_rq[$];
  wr_t mon_w;
  rd_t mon_r;

  // Reference model: phase 0 idle, 1 armed, 2 post, 3 done.
  int m_phase, m_n, m_post, m_pc, m_trig_addr;
  bit m_tv, m_ovf;
  int m_hist[$];
  int m_rdq[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear_run();
    m_n = 0; m_post = 0; m_trig_addr = 0; m_tv = 0; m_ovf = 0;
    m_hist.delete();
    m_rdq.delete();
  endfunction

  function automatic void model_reset();
    model_clear_run();
    m_phase = 0; m_pc = 0;
    exp_wq.delete();
    exp_rq.delete();
  endfunction

  function automatic void model_step(bit en, bit trig, bit wrdy, bit ab, bit arm, int pc,
                                     bit rn, bit rrdy, logic [WIDTH-1:0] d);
    bit active;
    bit w;
    bit to_done;
    int addr;
    int k;
    active  = (m_phase == 1) || (m_phase == 2);
    w       = active && en && wrdy;
    addr    = m_n % DEPTH;
    to_done = 0;
    if (w) begin
      exp_wq.push_back('{addr, d});
      m_hist.push_back(addr);
      m_n++;
    end
    if (active && en && !wrdy) m_ovf = 1;
    if (active && ab) begin
      to_done = 1;
    end else if (m_phase == 1 && w && trig) begin
      m_tv = 1;
      m_trig_addr = addr;
      if (m_pc == 0) to_done = 1;
      else begin
        m_phase = 2;
        m_post  = m_pc;
      end
    end else if (m_phase == 2 && w) begin
      m_post--;
      if (m_post == 0) to_done = 1;
    end
    if (to_done) begin
      m_phase = 3;
      k = (m_n < DEPTH) ? m_n : DEPTH;
      m_rdq.delete();
      for (int i = m_hist.size() - k; i < m_hist.size(); i++) m_rdq.push_back(m_hist[i]);
    end else if ((m_phase == 0 || m_phase == 3) && arm) begin
      model_clear_run();
      m_pc    = pc;
      m_phase = 1;
    end else if (m_phase == 3 && rn && rrdy && m_rdq.size() > 0) begin
      exp_rq.push_back('{m_rdq[0], m_rdq.size() == 1});
      void'(m_rdq.pop_front());
    end
  endfunction

  task automatic drive(input bit en, input bit trig, input bit wrdy, input bit ab,
                       input bit arm, input int pc, input bit rn, input bit rrdy);
    logic [WIDTH-1:0] d;
    d = {$urandom, $urandom};
    @(posedge CLK);
    #1;
    ifc.enable         = en;
    ifc.data           = d;
    ifc.trigger        = trig;
    ifc.bramWrite__RDY = wrdy;
    ifc.abort__ENA     = ab;
    ifc.arm__ENA       = arm;
    ifc.arm_postCount  = AW'(pc);
    ifc.readNext__ENA  = rn;
    ifc.bramRead__RDY  = rrdy;
    model_step(en, trig, wrdy, ab, arm, pc, rn, rrdy, d);
  endtask

  task automatic sample(input bit trig);
    drive(1, trig, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic rd();
    drive(0, 0, 1, 0, 0, 0, 1, 1);
  endtask

  task automatic arm(input int pc);
    drive(0, 0, 1, 0, 1, pc, 0, 1);
  endtask

  // Quiet cycle, then compare every status output against the model.
  task automatic check_status(input string tag);
    int fill_exp;
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    @(negedge CLK);
    #1;
    fill_exp = (m_n < DEPTH) ? m_n : DEPTH;
    check({tag, ".state"},     64'(ifc.state),          64'(m_phase));
    check({tag, ".fill"},      64'(ifc.fill),           64'(fill_exp));
    check({tag, ".trigAddr"},  64'(ifc.trigAddr),       64'(m_trig_addr));
    check({tag, ".trigValid"}, 64'(ifc.trigValid),      64'(m_tv));
    check({tag, ".overflow"},  64'(ifc.overflow),       64'(m_ovf));
    check({tag, ".wptr"},      64'(ifc.bramWrite_addr), 64'(m_n % DEPTH));
    check({tag, ".armRdy"},    64'(ifc.arm__RDY),       64'(m_phase == 0 || m_phase == 3));
    check({tag, ".abortRdy"},  64'(ifc.abort__RDY),     64'(m_phase == 1 || m_phase == 2));
    check({tag, ".readRdy"},   64'(ifc.readNext__RDY),  64'(m_phase == 3 && m_rdq.size() > 0));
    if (m_phase == 3 && m_rdq.size() > 0) begin
      check({tag, ".rptr"}, 64'(ifc.bramRead_addr), 64'(m_rdq[0]));
      check({tag, ".last"}, 64'(ifc.readNext_last), 64'(m_rdq.size() == 1));
    end
    check({tag, ".pendWr"}, 64'(exp_wq.size()), 64'd0);
    check({tag, ".pendRd"}, 64'(exp_rq.size()), 64'd0);
  endtask

  // Monitor: every DUT strobe must match the oldest expected transaction.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (ifc.bramWrite__ENA) begin
          if (exp_wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0d expected no write", ifc.bramWrite_addr);
          end else begin
            mon_w = exp_wq.pop_front();
            check("wr_addr", 64'(ifc.bramWrite_addr), 64'(mon_w.addr));
            check("wr_data", ifc.bramWrite_data, mon_w.data);
          end
        end
        if (ifc.bramRead__ENA) begin
          if (exp_rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: got addr %0d expected no read", ifc.bramRead_addr);
          end else begin
            mon_r = exp_rq.pop_front();
            check("rd_addr", 64'(ifc.bramRead_addr), 64'(mon_r.addr));
            check("rd_last", 64'(ifc.readNext_last), 64'(mon_r.last));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    ifc.enable = 0; ifc.data = '0; ifc.trigger = 0; ifc.bramWrite__RDY = 1;
    ifc.abort__ENA = 0; ifc.arm__ENA = 0; ifc.arm_postCount = '0;
    ifc.readNext__ENA = 0; ifc.bramRead__RDY = 1;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst.state", 64'(ifc.state), 64'd0);
    check("rst.armRdy", 64'(ifc.arm__RDY), 64'd1);
    RST = 0;
    repeat (10) drive(0, 0, 1, 0, 0, 0, 0, 1);
    check_status("idle");

    // Basic capture: trigger on sample 5, three post samples.
    arm(3);
    for (int i = 0; i < 9; i++) sample(i == 5);
    check_status("basic");
    for (int i = 0; i < 9; i++) rd();
    rd();
    check_status("basic_rd");

    // Wrapped capture: trigger at sample 21 lands on address 4.
    arm(2);
    for (int i = 0; i < 20; i++) sample(0);
    sample(1);
    sample(0);
    sample(0);
    check_status("wrap");
    for (int i = 0; i < 16; i++) rd();
    check_status("wrap_rd");

    // Write backpressure drops samples and sets overflow.
    arm(3);
    sample(0); sample(0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    sample(0);
    drive(0, 0, 1, 1, 0, 0, 0, 1);
    check_status("ovf");
    budget = 20;
    while (m_rdq.size() > 0 && budget > 0) begin rd(); budget--; end
    check_status("ovf_rd");

    // Abort with a trigger and a write in the same cycle.
    arm(3);
    for (int i = 0; i < 4; i++) sample(0);
    drive(1, 1, 1, 1, 0, 0, 0, 1);
    check_status("abort");

    // Zero post count, then arm colliding with a read request.
    arm(0);
    sample(1);
    check_status("pc0");
    drive(0, 0, 1, 0, 1, 5, 1, 1);
    check_status("arm_vs_read");

    // Asynchronous reset in the middle of POST.
    sample(0); sample(1); sample(0);
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    #2;
    RST = 1;
    #1;
    check("midrst.state", 64'(ifc.state), 64'd0);
    check("midrst.fill", 64'(ifc.fill), 64'd0);
    check("midrst.trigValid", 64'(ifc.trigValid), 64'd0);
    check("midrst.trigAddr", 64'(ifc.trigAddr), 64'd0);
    check("midrst.wrEna", 64'(ifc.bramWrite__ENA), 64'd0);
    check("midrst.abortRdy", 64'(ifc.abort__RDY), 64'd0);
    model_reset();
    @(negedge CLK);
    ifc.enable = 0;
    @(negedge CLK);
    RST = 0;
    check_status("post_rst");

    // Randomized runs.
    for (int run = 0; run < 10; run++) begin
      arm($urandom_range(0, 6));
      budget = 60;
      while ((m_phase == 1 || m_phase == 2) && budget > 0) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 6) != 0, $urandom_range(0, 30) == 0,
              0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        budget--;
      end
      if (m_phase != 3) drive(0, 0, 1, 1, 0, 0, 0, 1);
      check_status("rnd_cap");
      budget = 80;
      while (m_rdq.size() > 0 && budget > 0) begin
        drive($urandom_range(0, 1), 0, 1, 0, 0, 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) != 0);
        budget--;
      end
      check_status("rnd_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
